// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops, multi-cycle SHL (one bit per
// cycle) and shift-add MUL, with valid/ready handshakes on both sides.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       f,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010,
                           OP_OR  = 3'b011, OP_NOT = 3'b100, OP_XOR = 3'b101,
                           OP_SHL = 3'b110, OP_MUL = 3'b111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state;
    logic [2:0]           op;
    logic [2*WIDTH-1:0]   sa, prod;
    logic [WIDTH-1:0]     rb;
    logic [CW-1:0]        cnt, last;

    logic                 cin, ovf, go_busy;
    logic [WIDTH-1:0]     bb, alu_res;
    logic [WIDTH:0]       sum;
    logic                 alu_c;
    logic [CW-1:0]        amt;
    logic [2*WIDTH-1:0]   sa_nx, prod_nx;
    logic [WIDTH-1:0]     fin_res;
    logic                 fin_c, fin_v;
    logic [3:0]           fin_flags;

    // Live-operand datapath for the single-cycle ops; it is only consumed
    // on the accept edge, so it sees exactly the values being captured.
    always_comb begin
        cin     = (f == OP_SUB);
        bb      = cin ? ~b : b;
        sum     = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, cin};
        ovf     = (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        amt     = CW'(32'(b) % WIDTH);
        go_busy = (f == OP_MUL) || ((f == OP_SHL) && (amt != '0));
        alu_c   = 1'b0;
        case (f)
            OP_ADD, OP_SUB: begin alu_res = sum[WIDTH-1:0]; alu_c = sum[WIDTH]; end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_NOT:  alu_res = ~a;
            OP_XOR:  alu_res = a ^ b;
            default: alu_res = a;          // SHL by zero passes a through
        endcase
    end

    // One multi-cycle step: sa is shifted for both SHL and MUL (as multiplicand)
    always_comb begin
        sa_nx   = sa << 1;
        prod_nx = prod + (rb[0] ? sa : '0);
        if (state == BUSY) begin
            fin_v = 1'b0;
            if (op == OP_MUL) begin
                fin_res = prod_nx[WIDTH-1:0];
                fin_c   = |prod_nx[2*WIDTH-1:WIDTH];
            end else begin
                fin_res = sa_nx[WIDTH-1:0];
                fin_c   = sa[WIDTH-1];
            end
        end else begin
            fin_res = alu_res;
            fin_c   = alu_c;
            fin_v   = ((f == OP_ADD) || (f == OP_SUB)) ? ovf : 1'b0;
        end
        fin_flags = {fin_res[WIDTH-1], (fin_res == '0), fin_v, fin_c};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
            cnt       <= '0;
            last      <= '0;
            op        <= '0;
            sa        <= '0;
            prod      <= '0;
            rb        <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op       <= f;
                    sa       <= {{WIDTH{1'b0}}, a};
                    rb       <= b;
                    prod     <= '0;
                    cnt      <= '0;
                    in_ready <= 1'b0;
                    if (go_busy) begin
                        state <= BUSY;
                        last  <= (f == OP_MUL) ? CW'(WIDTH - 1) : amt - CW'(1);
                    end else begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= fin_res;
                        flags     <= fin_flags;
                    end
                end
                // cnt stops at last (step count - 1), so it never needs to hold WIDTH
                BUSY: begin
                    sa   <= sa_nx;
                    rb   <= rb >> 1;
                    prod <= prod_nx;
                    if (cnt == last) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= fin_res;
                        flags     <= fin_flags;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8): expectations queued at accept,
// checked every cycle the DUT presents a result.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, out_valid, out_ready;
    logic [2:0] f;
    logic [7:0] a, b, result;
    logic [3:0] flags;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit first_seen = 1'b0;

    typedef struct {
        logic [7:0] r;
        logic [3:0] fl;
        int         lat;
        int         acc;
    } exp_t;
    exp_t q[$];

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .f(f), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] model(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
        logic [8:0]  s;
        logic [15:0] p;
        logic [7:0]  r;
        logic        c, v;
        int          n;
        c = 1'b0; v = 1'b0; r = '0;
        case (op)
            3'd0: begin s = {1'b0, x} + {1'b0, y}; r = s[7:0]; c = s[8];
                        v = (x[7] == y[7]) && (r[7] != x[7]); end
            3'd1: begin s = {1'b0, x} + {1'b0, ~y} + 9'd1; r = s[7:0]; c = s[8];
                        v = (x[7] != y[7]) && (r[7] != x[7]); end
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = ~x;
            3'd5: r = x ^ y;
            3'd6: begin n = int'(y) % 8; r = x << n; c = (n == 0) ? 1'b0 : x[8-n]; end
            default: begin p = 16'(x) * 16'(y); r = p[7:0]; c = |p[15:8]; end
        endcase
        return {r[7], (r == 8'd0), v, c, r};
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [7:0] y);
        if (op == 3'd7) return 9;
        if (op == 3'd6) return (int'(y) % 8 == 0) ? 1 : (int'(y) % 8) + 1;
        return 1;
    endfunction

    // Caller is always just after a rising edge.
    task automatic send(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] er, input logic [3:0] ef, input int el);
        int n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (!in_ready) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
        f = op; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        f = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
        q.push_back('{er, ef, el, cyc});
    endtask

    task automatic send_m(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
        logic [11:0] m;
        m = model(op, x, y);
        send(op, x, y, m[7:0], m[11:8], model_lat(op, y));
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 200) begin @(posedge clk); #1; n++; end
        if (q.size() > 0) chk("drain_timeout", q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (q.size() == 0) begin
                chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
                if (out_valid) begin
                    chk("result", {24'd0, result}, {24'd0, q[0].r});
                    chk("flags", {28'd0, flags}, {28'd0, q[0].fl});
                    if (!first_seen) begin
                        chk("latency", cyc - q[0].acc, q[0].lat - 1);
                        first_seen = 1'b1;
                    end
                    if (out_ready) begin
                        void'(q.pop_front());
                        first_seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b1; f = 3'd0; a = 8'd5; b = 8'd5; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", {24'd0, result}, 32'd0);
        chk("rst_flags", {28'd0, flags}, 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

        send(3'd0, 8'd6,   8'd4,  8'd10,  4'b0000, 1); drain();
        send(3'd1, 8'd6,   8'd4,  8'd2,   4'b0001, 1); drain();
        send(3'd0, 8'd127, 8'd1,  8'd128, 4'b1010, 1); drain();
        send(3'd1, 8'd0,   8'd1,  8'd255, 4'b1000, 1); drain();
        send(3'd7, 8'd16,  8'd17, 8'h10,  4'b0001, 9); drain();
        send(3'd6, 8'h81,  8'd3,  8'h08,  4'b0000, 4); drain();
        send(3'd6, 8'h81,  8'd9,  8'h02,  4'b0001, 2); drain();
        send(3'd6, 8'h80,  8'd8,  8'h80,  4'b1000, 1); drain();
        send(3'd7, 8'd0,   8'd55, 8'h00,  4'b0100, 9); drain();
        send(3'd4, 8'h0F,  8'd0,  8'hF0,  4'b1000, 1); drain();

        // Backpressure: result held, in_valid ignored while DONE
        out_ready = 1'b0;
        send(3'd2, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1);
        in_valid = 1'b1; f = 3'd0; a = 8'd1; b = 8'd1;
        repeat (5) begin @(posedge clk); #1; end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_out_valid", {31'd0, out_valid}, 32'd0);

        // Reset in the 4th cycle of a MUL aborts it
        send(3'd7, 8'd200, 8'd3, 8'h58, 4'b0001, 9);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        first_seen = 1'b0;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_result", {24'd0, result}, 32'd0);
        send(3'd0, 8'd1, 8'd1, 8'd2, 4'b0000, 1); drain();

        for (int i = 0; i < 40; i++) begin
            send_m(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
